pn22_checker: RTL and testbench

Receive-side counterpart of the 22-bit PN generator: a self-synchronizing checker for the maximal-length sequence x^22 + x^21 + 1.
- Acquires the incoming serial PN stream one bit per sam_clk_en strobe.
- Declares lock, then flywheels its own copy of the sequence.
- Counts bit errors and total bits for BER measurement, and drops lock on excessive windowed errors.
- Sits at the demodulator/slicer output in the loopback BER path, on the same clk/clk_en timing as the generator.

---
 rtl/pn22_checker.sv | 157 +++++++++++++++
 tb/tb_pn22_checker.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pn22_checker.sv
// pn22_checker: self-synchronizing receive checker for the x^22 + x^21 + 1 PN sequence.
// Acquires from the line, flywheels its own copy once locked, and accumulates BER counts.
module pn22_checker #(
    parameter int N           = 22,
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sam_clk_en,
    input  logic             data_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);
    localparam int FW = $clog2(N);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_VERIFY,
        S_LOCKED
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_sr;
    logic [FW-1:0]    r_fill;
    logic [MW-1:0]    r_match;
    logic [WW-1:0]    r_win_cnt;
    logic [EW-1:0]    r_win_err;
    logic             r_pulse;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_bit_cnt;

    state_t           w_state_nxt;
    logic [N-1:0]     w_sr_nxt;
    logic [FW-1:0]    w_fill_nxt;
    logic [MW-1:0]    w_match_nxt;
    logic [WW-1:0]    w_win_cnt_nxt;
    logic [EW-1:0]    w_win_err_nxt;
    logic [EW-1:0]    w_win_base;
    logic [EW-1:0]    w_win_sum;
    logic             w_pulse_nxt;
    logic             w_err_inc;
    logic             w_bit_inc;
    logic             w_p;
    logic             w_m;

    assign w_p = r_sr[N-1] ^ r_sr[N-2];
    assign w_m = data_in ^ w_p;

    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_fill_nxt    = r_fill;
        w_match_nxt   = r_match;
        w_win_cnt_nxt = r_win_cnt;
        w_win_err_nxt = r_win_err;
        w_win_base    = '0;
        w_win_sum     = '0;
        w_pulse_nxt   = 1'b0;
        w_err_inc     = 1'b0;
        w_bit_inc     = 1'b0;
        if (sam_clk_en) begin
            unique case (r_state)
                S_FILL: begin
                    w_sr_nxt = {r_sr[N-2:0], data_in};
                    if (r_fill == FW'(N - 1)) begin
                        w_state_nxt = S_VERIFY;
                        w_fill_nxt  = '0;
                        w_match_nxt = '0;
                    end else begin
                        w_fill_nxt = r_fill + FW'(1);
                    end
                end
                S_VERIFY: begin
                    w_sr_nxt = {r_sr[N-2:0], data_in};
                    // All-zero is the LFSR lock-up state; it must never count toward lock
                    if (r_sr == '0 || w_m) begin
                        w_match_nxt = '0;
                    end else if (r_match == MW'(LOCK_COUNT - 1)) begin
                        w_state_nxt   = S_LOCKED;
                        w_match_nxt   = '0;
                        w_win_cnt_nxt = '0;
                        w_win_err_nxt = '0;
                    end else begin
                        w_match_nxt = r_match + MW'(1);
                    end
                end
                S_LOCKED: begin
                    // Flywheel: feed back the prediction so a line error is counted once
                    w_sr_nxt      = {r_sr[N-2:0], w_p};
                    w_bit_inc     = 1'b1;
                    w_err_inc     = w_m;
                    w_pulse_nxt   = w_m;
                    w_win_cnt_nxt = (r_win_cnt == WW'(WINDOW - 1)) ?
                                    '0 : r_win_cnt + WW'(1);
                    w_win_base    = (r_win_cnt == '0) ? '0 : r_win_err;
                    w_win_sum     = w_win_base + EW'(w_m);
                    w_win_err_nxt = w_win_sum;
                    if (w_win_sum == EW'(LOSS_THRESH)) begin
                        w_state_nxt = S_FILL;
                        w_fill_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_FILL;
                    w_fill_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_FILL;
            r_sr      <= '0;
            r_fill    <= '0;
            r_match   <= '0;
            r_win_cnt <= '0;
            r_win_err <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_fill    <= w_fill_nxt;
            r_match   <= w_match_nxt;
            r_win_cnt <= w_win_cnt_nxt;
            r_win_err <= w_win_err_nxt;
            r_pulse   <= w_pulse_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr_cnt) begin
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_bit_inc && r_bit_cnt != '1)
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (w_err_inc && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign locked    = (r_state == S_LOCKED);
    assign err_pulse = r_pulse;
    assign err_count = r_err_cnt;
    assign bit_count = r_bit_cnt;

endmodule

// File: tb/tb_pn22_checker.sv
// tb_pn22_checker: randomized stimulus against a sequence-level model of the PN checker.
// Directed scenarios pin lock latency, flywheel, window loss and counter clearing.
`timescale 1ns/1ps
module tb_pn22_checker;
    localparam int N   = 22;
    localparam int LC  = 32;
    localparam int WIN = 64;
    localparam int LT  = 8;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sam_clk_en = 1'b0;
    logic          data_in = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] bit_count;

    pn22_checker #(
        .N(N), .LOCK_COUNT(LC), .WINDOW(WIN),
        .LOSS_THRESH(LT), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en),
        .data_in(data_in), .clr_cnt(clr_cnt), .locked(locked),
        .err_pulse(err_pulse), .err_count(err_count),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    bit gen_q[$];
    bit mq[$];
    int acq_n, run_n, lk_n, cur_win, win_err;
    bit m_locked;
    logic          exp_locked, exp_pulse;
    logic [CW-1:0] exp_err, exp_bits;

    function automatic void gen_reset();
        gen_q = {};
        repeat (N) gen_q.push_back(1'b1);
    endfunction

    function automatic bit gen_next();
        bit b;
        b = gen_q[0];
        gen_q.push_back(gen_q[0] ^ gen_q[1]);
        void'(gen_q.pop_front());
        return b;
    endfunction

    function automatic void model_reset();
        mq = {};
        repeat (N) mq.push_back(1'b0);
        acq_n = 0; run_n = 0; lk_n = 0; cur_win = 0; win_err = 0;
        m_locked = 1'b0;
        exp_locked = 1'b0; exp_pulse = 1'b0;
        exp_err = '0; exp_bits = '0;
    endfunction

    // q[0] is the oldest of the last N local bits; prediction is b[k-22]^b[k-21]
    function automatic void model_step(input bit en, input bit d, input bit clr);
        bit pred, e, zero;
        exp_pulse = 1'b0;
        if (en) begin
            pred = mq[0] ^ mq[1];
            if (!m_locked) begin
                if (acq_n >= N) begin
                    zero = 1'b1;
                    foreach (mq[i]) if (mq[i]) zero = 1'b0;
                    if (zero || d != pred) run_n = 0;
                    else run_n++;
                    if (run_n == LC) begin
                        m_locked = 1'b1;
                        lk_n = 0; cur_win = 0; win_err = 0; run_n = 0;
                    end
                end
                mq.push_back(d);
                acq_n++;
            end else begin
                e = d ^ pred;
                if (lk_n / WIN != cur_win) begin
                    cur_win = lk_n / WIN;
                    win_err = 0;
                end
                win_err += int'(e);
                exp_pulse = e;
                if (exp_bits != '1) exp_bits = exp_bits + 1;
                if (e && exp_err != '1) exp_err = exp_err + 1;
                mq.push_back(pred);
                lk_n++;
                if (win_err >= LT) begin
                    m_locked = 1'b0;
                    acq_n = 0; run_n = 0;
                end
            end
            void'(mq.pop_front());
        end
        if (clr) begin
            exp_err = '0;
            exp_bits = '0;
        end
        exp_locked = m_locked;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (locked !== exp_locked || err_pulse !== exp_pulse ||
                err_count !== exp_err || bit_count !== exp_bits) begin
                miscompares++;
                $display("FAIL model t=%0t: locked %b want %b, pulse %b want %b, err %0d want %0d, bits %0d want %0d",
                         $time, locked, exp_locked, err_pulse, exp_pulse,
                         err_count, exp_err, bit_count, exp_bits);
            end
        end
    end

    task automatic check(input string nm, input logic [CW-1:0] act,
                         input logic [CW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit en, input bit d, input bit clr);
        @(negedge clk);
        sam_clk_en = en;
        data_in = d;
        clr_cnt = clr;
        @(posedge clk);
        model_step(en, d, clr);
    endtask

    task automatic send(input bit d, input bit clr);
        repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 1'b0);
        step(1'b1, d, clr);
    endtask

    task automatic send_pn(input bit flip, input bit clr);
        send(gen_next() ^ flip, clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sam_clk_en = 1'b0;
        clr_cnt = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic acquire(input string nm);
        for (int i = 1; i <= N + LC; i++) begin
            send_pn(1'b0, 1'b0);
            if (i == N + LC - 1) begin
                #1 check({nm, " not locked at 53"}, CW'(locked), 0);
            end
        end
        #1 check({nm, " locked at 54"}, CW'(locked), 1);
    endtask

    initial begin
        #2ms;
        miscompares++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int pos[8];
        int last;
        bit f;
        gen_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset locked", CW'(locked), 0);
        check("reset pulse", CW'(err_pulse), 0);
        check("reset err", err_count, 0);
        check("reset bits", bit_count, 0);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b1;

        // clean acquisition then 1000 clean bits
        gen_reset();
        acquire("t1");
        repeat (1000) send_pn(1'b0, 1'b0);
        #1;
        check("t1 bits", bit_count, 1000);
        check("t1 err", err_count, 0);

        // single inverted bit: flywheel counts it once
        send_pn(1'b1, 1'b0);
        #1;
        check("t2 pulse", CW'(err_pulse), 1);
        check("t2 err now", err_count, 1);
        repeat (100) send_pn(1'b0, 1'b0);
        #1;
        check("t2 err after", err_count, 1);
        check("t2 locked", CW'(locked), 1);
        check("t2 bits", bit_count, 1101);

        // all-zero input never locks
        do_reset();
        repeat (500) send(1'b0, 1'b0);
        #1;
        check("t3 locked", CW'(locked), 0);
        check("t3 err", err_count, 0);
        check("t3 bits", bit_count, 0);

        // 8 errors inside the first locked window drop lock
        do_reset();
        gen_reset();
        acquire("t4");
        for (int k = 0; k < 8; k++) pos[k] = k * 8 + $urandom_range(0, 7);
        last = pos[7];
        for (int j = 0; j <= last; j++) begin
            f = 1'b0;
            foreach (pos[k]) if (pos[k] == j) f = 1'b1;
            send_pn(f, 1'b0);
            if (j == pos[6]) begin
                #1 check("t4 locked after 7", CW'(locked), 1);
            end
        end
        #1 check("t4 lost on 8th", CW'(locked), 0);
        acquire("t4 relock");
        check("t4 err kept", err_count, 8);

        // 7 + 7 errors straddling a window boundary keep lock
        do_reset();
        gen_reset();
        acquire("t5");
        for (int j = 0; j < 128; j++) send_pn(j >= 57 && j <= 70, 1'b0);
        #1;
        check("t5 locked", CW'(locked), 1);
        check("t5 err", err_count, 14);

        // clear beats a same-cycle error; pulse still fires
        send_pn(1'b1, 1'b1);
        #1;
        check("t6 pulse", CW'(err_pulse), 1);
        check("t6 err", err_count, 0);
        check("t6 bits", bit_count, 0);
        send_pn(1'b0, 1'b0);
        #1 check("t6 bits after", bit_count, 1);

        // one-clock reset mid-lock
        @(negedge clk);
        reset = 1'b0;
        sam_clk_en = 1'b1;
        data_in = 1'($urandom);
        @(posedge clk);
        model_reset();
        #1;
        check("t6 rst locked", CW'(locked), 0);
        check("t6 rst pulse", CW'(err_pulse), 0);
        check("t6 rst err", err_count, 0);
        check("t6 rst bits", bit_count, 0);
        @(negedge clk);
        reset = 1'b1;
        sam_clk_en = 1'b0;
        acquire("t6 refill");

        // randomized soak: clean, noisy and junk phases with occasional clears
        for (int ph = 0; ph < 12; ph++) begin
            int kind;
            kind = $urandom_range(0, 2);
            for (int j = 0; j < 300; j++) begin
                bit c;
                c = ($urandom_range(0, 199) == 0);
                if (kind == 0) send_pn(1'b0, c);
                else if (kind == 1) send_pn($urandom_range(0, 9) == 0, c);
                else begin
                    void'(gen_next());
                    send(1'($urandom), c);
                end
            end
        end

        @(negedge clk);
        sam_clk_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
